param_loader: RTL and testbench

PARAM_LOADER -- requirements
Module: param_loader

---
 rtl/cnn_param_pkg.sv | 36 +++
 rtl/param_ram.sv | 25 ++
 rtl/param_loader.sv | 109 ++++++++++
 tb/tb_param_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_param_pkg.sv
// Shared definitions for the CNN parameter loaders: FSM encoding and per-layer
// buffer depths (weights and biases).
package cnn_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } loader_state_t;

    localparam int unsigned PARAM_WORD_W        = 32;
    localparam int unsigned PARAM_DEPTH_DEFAULT = 180;

    // Weight depth = 3x3 kernel x input channels x filters; bias depth = filters.
    localparam int unsigned CONV1_W_DEPTH  = 3 * 3 * 1 * 20;
    localparam int unsigned CONV1_B_DEPTH  = 20;
    localparam int unsigned CONV2_W_DEPTH  = 3 * 3 * 20 * 20;
    localparam int unsigned CONV2_B_DEPTH  = 20;
    localparam int unsigned CONV3_W_DEPTH  = 3 * 3 * 20 * 20;
    localparam int unsigned CONV3_B_DEPTH  = 20;
    localparam int unsigned CONV4_W_DEPTH  = 3 * 3 * 20 * 20;
    localparam int unsigned CONV4_B_DEPTH  = 20;
    localparam int unsigned DENSE1_W_DEPTH = 320 * 64;
    localparam int unsigned DENSE1_B_DEPTH = 64;
    localparam int unsigned DENSE2_W_DEPTH = 64 * 10;
    localparam int unsigned DENSE2_B_DEPTH = 10;

    // Smallest address width that covers a buffer of the given depth.
    function automatic int unsigned param_addr_w(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/param_ram.sv
// Single-port parameter storage with synchronous read, DEPTH x 32 bits.
// The read register only updates on a read so it holds its value otherwise.
module param_ram #(
    parameter int unsigned DEPTH  = 180,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/param_loader.sv
// Streams DEPTH parameter words into a local RAM in arrival order, then serves
// one-cycle-latency reads once the buffer is full.
module param_loader
    import cnn_param_pkg::*;
#(
    parameter int unsigned DEPTH  = PARAM_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              control_in,
    input  logic [31:0]       data_in,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              loaded,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    loader_state_t   r_state;
    logic [ADDR_W:0] r_count;
    logic            r_loaded;
    logic            r_overflow;
    logic            r_rd_valid;
    logic            r_rd_seen;
    logic            r_rd_oob;

    logic              w_wr;
    logic              w_rd_acc;
    logic              w_in_range;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_q;

    assign w_wr       = control_in && !clear && !rst_ && (r_state != ST_FULL);
    assign w_rd_acc   = rd_en && r_loaded && !rst_;
    assign w_in_range = ({1'b0, rd_addr} < DEPTH_CNT);
    assign w_ram_re   = w_rd_acc && w_in_range;
    // Single port: writes only happen before FULL, reads only in FULL.
    assign w_ram_addr = w_wr ? r_count[ADDR_W-1:0] : rd_addr;

    param_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (data_in),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_loaded   <= 1'b0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_seen <= 1'b1;
                r_rd_oob  <= !w_in_range;
            end
            if (clear) begin
                r_state    <= ST_IDLE;
                r_count    <= '0;
                r_loaded   <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    // IDLE and LOAD share the append path; DEPTH=1 exits from IDLE.
                    ST_IDLE, ST_LOAD: begin
                        if (control_in) begin
                            r_count <= r_count + 1'b1;
                            if (r_count == LAST_CNT) begin
                                r_state  <= ST_FULL;
                                r_loaded <= 1'b1;
                            end else begin
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (control_in) r_overflow <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rd_data    = (r_rd_seen && !r_rd_oob) ? w_ram_q : '0;
    assign rd_valid   = r_rd_valid;
    assign loaded     = r_loaded;
    assign load_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: a DEPTH=180 instance and a DEPTH=20
// instance for the gapped-load scenario.
module tb_param_loader;

    logic        clk = 1'b0;
    logic        rst_, control_in, clear, rd_en;
    logic [31:0] data_in;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid, loaded, overflow;
    logic [8:0]  load_count;

    logic        b_rst_, b_control_in, b_clear, b_rd_en;
    logic [31:0] b_data_in;
    logic [4:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic        b_rd_valid, b_loaded, b_overflow;
    logic [5:0]  b_load_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_loader #(.DEPTH(180), .ADDR_W(8)) dut (
        .clk(clk), .rst_(rst_), .control_in(control_in), .data_in(data_in),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .loaded(loaded), .load_count(load_count),
        .overflow(overflow)
    );

    param_loader #(.DEPTH(20), .ADDR_W(5)) dut20 (
        .clk(clk), .rst_(b_rst_), .control_in(b_control_in), .data_in(b_data_in),
        .clear(b_clear), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .loaded(b_loaded), .load_count(b_load_count),
        .overflow(b_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ = 1'b1; control_in = 1'b1; clear = 1'b1; rd_en = 1'b1;
        data_in = 32'h1234; rd_addr = 8'd0;
        b_rst_ = 1'b1; b_control_in = 1'b0; b_clear = 1'b0; b_rd_en = 1'b0;
        b_data_in = '0; b_rd_addr = '0;
        step();
        step();
        rst_ = 1'b0; control_in = 1'b0; clear = 1'b0; rd_en = 1'b0;
        b_rst_ = 1'b0;
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got %b want 0", loaded); end
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", load_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (b_load_count !== 6'd0) begin errors++; $display("FAIL reset20_count got %0d want 0", b_load_count); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 180; k++) begin
            control_in = 1'b1; data_in = 32'(k);
            step();
            if (k == 178) begin
                checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL b2b_early_loaded got %b want 0", loaded); end
            end
        end
        control_in = 1'b0;
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL b2b_loaded got %b want 1", loaded); end
        checks++; if (load_count !== 9'd180) begin errors++; $display("FAIL b2b_count got %0d want 180", load_count); end
        rd_en = 1'b1; rd_addr = 8'd37;
        step();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid got %b want 1", rd_valid); end
        checks++; if (rd_data !== 32'd37) begin errors++; $display("FAIL b2b_rd37 got %0d want 37", rd_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", rd_valid); end
        checks++; if (rd_data !== 32'd37) begin errors++; $display("FAIL b2b_rd_hold got %0d want 37", rd_data); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            control_in = 1'b1; data_in = 32'hDEADBEEF;
            step();
        end
        control_in = 1'b0;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (load_count !== 9'd180) begin errors++; $display("FAIL ovf_count got %0d want 180", load_count); end
        rd_en = 1'b1; rd_addr = 8'd179;
        step();
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'd179) begin errors++; $display("FAIL ovf_addr179 got %h want b3", rd_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_out_of_range();
        rd_en = 1'b1; rd_addr = 8'd200;
        step();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL oob_valid got %b want 1", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL oob_data got %h want 0", rd_data); end
    endtask

    task automatic test_clear_with_word();
        clear = 1'b1; control_in = 1'b1; data_in = 32'h55;
        step();
        clear = 1'b0; control_in = 1'b0;
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL clr_loaded got %b want 0", loaded); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL clr_count got %0d want 0", load_count); end
        rd_en = 1'b1; rd_addr = 8'd5;
        step();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL unloaded_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL unloaded_hold got %h want 0", rd_data); end
        control_in = 1'b1; data_in = 32'hABC;
        step();
        checks++; if (load_count !== 9'd1) begin errors++; $display("FAIL clr_first_count got %0d want 1", load_count); end
        for (int k = 1; k < 180; k++) begin
            data_in = 32'(2000 + k);
            step();
        end
        control_in = 1'b0;
        rd_en = 1'b1; rd_addr = 8'd0;
        step();
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'hABC) begin errors++; $display("FAIL clr_addr0 got %h want abc", rd_data); end
    endtask

    task automatic test_reset_mid_load();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 90; k++) begin
            control_in = 1'b1; data_in = 32'(k);
            step();
        end
        rst_ = 1'b1; control_in = 1'b1; data_in = 32'd90;
        step();
        rst_ = 1'b0; control_in = 1'b0;
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", load_count); end
        for (int k = 0; k < 180; k++) begin
            control_in = 1'b1; data_in = 32'(1000 + k);
            step();
            if (k == 178) begin
                checks++; if (loaded !== 1'b0 || load_count !== 9'd179) begin
                    errors++; $display("FAIL rmid_early loaded=%b count=%0d want 0/179", loaded, load_count);
                end
            end
        end
        control_in = 1'b0;
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL rmid_loaded got %b want 1", loaded); end
        rd_en = 1'b1; rd_addr = 8'd0;
        step();
        checks++; if (rd_data !== 32'd1000) begin errors++; $display("FAIL rmid_addr0 got %0d want 1000", rd_data); end
        rd_addr = 8'd90;
        step();
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'd1090) begin errors++; $display("FAIL rmid_addr90 got %0d want 1090", rd_data); end
    endtask

    task automatic test_gapped();
        for (int c = 0; c < 39; c++) begin
            b_control_in = (c % 2 == 0);
            b_data_in = 32'(100 + c / 2);
            step();
            if (c == 37) begin
                checks++; if (b_load_count !== 6'd19) begin errors++; $display("FAIL gap_count38 got %0d want 19", b_load_count); end
            end
        end
        b_control_in = 1'b0;
        checks++; if (b_load_count !== 6'd20) begin errors++; $display("FAIL gap_count39 got %0d want 20", b_load_count); end
        checks++; if (b_loaded !== 1'b1) begin errors++; $display("FAIL gap_loaded got %b want 1", b_loaded); end
        for (int i = 0; i < 20; i++) begin
            b_rd_en = 1'b1; b_rd_addr = 5'(i);
            step();
            checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'(100 + i)) begin
                errors++; $display("FAIL gap_read[%0d] valid=%b data=%0d want 1/%0d", i, b_rd_valid, b_rd_data, 100 + i);
            end
        end
        b_rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_out_of_range();
        test_clear_with_word();
        test_reset_mid_load();
        test_gapped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
